// File: rtl/inst_queue_dual_if.sv
// -----------------------------------------------------------------------------
// inst_queue_dual_if
// Handshake/data bundle between the fetch-side IF stage, the dual-lane
// instruction queue and the dual-issue launch stage.
//
// Signals:
//   line1_pre_to_now_valid_i  upstream lane1 entry valid (lane1 is older)
//   line2_pre_to_now_valid_i  upstream lane2 entry valid
//   pre_to_ibus               {lane2, lane1} entries, each {pc, inst}
//   now_allowin_o             queue accepts a push this cycle
//   next_allowin_i            launch accepts entries this cycle
//   next_double_i             launch issues both lines
//   line1_now_to_next_valid_o head entry valid
//   line2_now_to_next_valid_o head+1 entry valid
//   to_next_obus              {head+1, head}
//
// Modports:
//   slave  - the queue
//   master - the environment driving the queue (fetch + launch side)
// -----------------------------------------------------------------------------
interface inst_queue_dual_if #(
    parameter int ENTRY_W = 64
);
    logic                   line1_pre_to_now_valid_i;
    logic                   line2_pre_to_now_valid_i;
    logic [2*ENTRY_W-1:0]   pre_to_ibus;
    logic                   now_allowin_o;
    logic                   next_allowin_i;
    logic                   next_double_i;
    logic                   line1_now_to_next_valid_o;
    logic                   line2_now_to_next_valid_o;
    logic [2*ENTRY_W-1:0]   to_next_obus;

    modport slave (
        input  line1_pre_to_now_valid_i,
        input  line2_pre_to_now_valid_i,
        input  pre_to_ibus,
        output now_allowin_o,
        input  next_allowin_i,
        input  next_double_i,
        output line1_now_to_next_valid_o,
        output line2_now_to_next_valid_o,
        output to_next_obus
    );

    modport master (
        output line1_pre_to_now_valid_i,
        output line2_pre_to_now_valid_i,
        output pre_to_ibus,
        input  now_allowin_o,
        output next_allowin_i,
        output next_double_i,
        input  line1_now_to_next_valid_o,
        input  line2_now_to_next_valid_o,
        input  to_next_obus
    );
endinterface

// File: rtl/inst_queue_dual.sv
// -----------------------------------------------------------------------------
// inst_queue_dual
// Dual-lane instruction queue between IF and the dual-issue launch stage.
// Accepts up to two {pc, inst} entries per cycle, presents the two oldest
// entries to launch and retires 0/1/2 entries per cycle. Emptied on branch or
// exception flush.
//
// Optional feature macro: IQ_BYPASS_EN
//   defined   - while the queue is empty, incoming lanes fall through to the
//               outputs in the same cycle; entries popped that cycle are not
//               written.
//   undefined - outputs depend only on registered state (>=1 cycle latency).
//
// Ports:
//   clk             clock
//   rst_n           synchronous active-low reset
//   excep_flush_i   exception flush, empties the queue
//   branch_flush_i  branch flush, empties the queue
//   q_if            push/present/pop bundle (slave side)
//   count_o         occupied entries
// -----------------------------------------------------------------------------
module inst_queue_dual #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   excep_flush_i,
    input  logic                   branch_flush_i,
    inst_queue_dual_if.slave       q_if,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               flush;
    logic               allowin;
    logic [ENTRY_W-1:0] lane1;
    logic [ENTRY_W-1:0] lane2;
    logic [1:0]         in_n;
    logic [ENTRY_W-1:0] in_e0;
    logic [ENTRY_W-1:0] in_e1;
    logic [ENTRY_W-1:0] head;
    logic [ENTRY_W-1:0] head1;
    logic               l1v_out;
    logic               l2v_out;
    logic [2*ENTRY_W-1:0] obus;
    logic [1:0]         pop_n;
    logic [1:0]         wr_n;
    logic [ENTRY_W-1:0] wr_e0;
    logic [1:0]         rd_adv;
    logic [CNT_W-1:0]   count_next;

    assign flush   = excep_flush_i | branch_flush_i;
    // Space for a full pair is required; a same-cycle pop is not credited.
    assign allowin = (count <= CNT_W'(DEPTH - 2));

    assign lane1 = q_if.pre_to_ibus[ENTRY_W-1:0];
    assign lane2 = q_if.pre_to_ibus[2*ENTRY_W-1:ENTRY_W];

    // Compact valid lanes: a lone lane2 entry becomes the first entry.
    assign in_n  = allowin ? ({1'b0, q_if.line1_pre_to_now_valid_i} +
                              {1'b0, q_if.line2_pre_to_now_valid_i}) : 2'd0;
    assign in_e0 = q_if.line1_pre_to_now_valid_i ? lane1 : lane2;
    assign in_e1 = lane2;

    assign head  = mem[rd_ptr];
    assign head1 = mem[rd_ptr + PTR_W'(1)];

    always_comb begin
        l1v_out = (count != '0);
        l2v_out = (count >= CNT_W'(2));
        obus    = {head1, head};
`ifdef IQ_BYPASS_EN
        if (count == '0) begin
            l1v_out = (in_n != 2'd0);
            l2v_out = (in_n == 2'd2);
            obus    = {in_e1, in_e0};
        end
`endif
        if (flush) begin
            l1v_out = 1'b0;
            l2v_out = 1'b0;
        end
    end

    always_comb begin
        pop_n = 2'd0;
        if (q_if.next_allowin_i && l1v_out) begin
            pop_n = (q_if.next_double_i && l2v_out) ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        wr_n   = in_n;
        wr_e0  = in_e0;
        rd_adv = pop_n;
`ifdef IQ_BYPASS_EN
        // Fall-through: popped entries never touch storage; rd_ptr stays put
        // because the surviving entries land at wr_ptr == rd_ptr.
        if (count == '0) begin
            wr_n   = in_n - pop_n;
            wr_e0  = (pop_n == 2'd1) ? in_e1 : in_e0;
            rd_adv = 2'd0;
        end
`endif
    end

    assign count_next = count + CNT_W'(wr_n) - CNT_W'(rd_adv);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr + PTR_W'(rd_adv);
            wr_ptr <= wr_ptr + PTR_W'(wr_n);
        end
    end

    // Storage is not reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (wr_n != 2'd0) mem[wr_ptr] <= wr_e0;
            if (wr_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= in_e1;
        end
    end

    assign q_if.now_allowin_o             = allowin;
    assign q_if.line1_now_to_next_valid_o = l1v_out;
    assign q_if.line2_now_to_next_valid_o = l2v_out;
    assign q_if.to_next_obus              = obus;
    assign count_o                        = count;

endmodule

// File: tb/tb_inst_queue_dual.sv
module tb_inst_queue_dual;
    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       excep_flush_i = 1'b0;
    logic       branch_flush_i = 1'b0;
    logic [3:0] count_o;

    inst_queue_dual_if #(.ENTRY_W(ENTRY_W)) iq_if ();

    inst_queue_dual #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .excep_flush_i  (excep_flush_i),
        .branch_flush_i (branch_flush_i),
        .q_if           (iq_if),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    bit          mon_en  = 1'b0;
    bit          allow_s = 1'b1;

    function automatic logic [63:0] mk(input logic [31:0] pc);
        return {pc, pc ^ 32'h0002_0013};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares presented lines with the scoreboard and retires
    // whatever launch consumes this cycle.
    always @(negedge clk) begin : monitor
        int sz;
        bit fl;
        bit e1;
        bit e2;
        sz = exp_q.size();
        fl = excep_flush_i | branch_flush_i;
        allow_s = (sz <= DEPTH - 2);
        if (mon_en) begin
            e1 = (sz >= 1) && !fl;
            e2 = (sz >= 2) && !fl;
            check("count_o", 64'(count_o), 64'(sz));
            check("now_allowin", 64'(iq_if.now_allowin_o), 64'(allow_s));
            check("line1_valid", 64'(iq_if.line1_now_to_next_valid_o), 64'(e1));
            check("line2_valid", 64'(iq_if.line2_now_to_next_valid_o), 64'(e2));
            if (e1 && iq_if.line1_now_to_next_valid_o)
                check("line1_data", iq_if.to_next_obus[63:0], exp_q[0]);
            if (e2 && iq_if.line2_now_to_next_valid_o)
                check("line2_data", iq_if.to_next_obus[127:64], exp_q[1]);
            if (iq_if.next_allowin_i && e1) begin
                void'(exp_q.pop_front());
                if (iq_if.next_double_i && e2) void'(exp_q.pop_front());
            end
        end
    end

    // Scoreboard feed: accepted pushes become expected entries.
    always @(posedge clk) begin
        if (!rst_n || excep_flush_i || branch_flush_i) begin
            exp_q.delete();
        end else if (allow_s) begin
            if (iq_if.line1_pre_to_now_valid_i) exp_q.push_back(iq_if.pre_to_ibus[63:0]);
            if (iq_if.line2_pre_to_now_valid_i) exp_q.push_back(iq_if.pre_to_ibus[127:64]);
        end
    end

    task automatic drive(input bit v1, input logic [31:0] pc1, input bit v2, input logic [31:0] pc2,
                         input bit na, input bit nd, input bit bf = 1'b0, input bit ef = 1'b0);
        iq_if.line1_pre_to_now_valid_i = v1;
        iq_if.line2_pre_to_now_valid_i = v2;
        iq_if.pre_to_ibus              = {mk(pc2), mk(pc1)};
        iq_if.next_allowin_i           = na;
        iq_if.next_double_i            = nd;
        branch_flush_i                 = bf;
        excep_flush_i                  = ef;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit na, input bit nd, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, na, nd);
    endtask

    initial begin
        logic [31:0] pc;
        iq_if.line1_pre_to_now_valid_i = 1'b0;
        iq_if.line2_pre_to_now_valid_i = 1'b0;
        iq_if.pre_to_ibus              = '0;
        iq_if.next_allowin_i           = 1'b0;
        iq_if.next_double_i            = 1'b0;

        // Reset for two cycles
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        check("reset_count", 64'(count_o), 64'd0);
        check("reset_allowin", 64'(iq_if.now_allowin_o), 64'd1);
        idle(1'b0, 1'b0, 1);

        // First pair, held while launch stalls
        drive(1'b1, 32'h1C00_0000, 1'b1, 32'h1C00_0004, 1'b0, 1'b0);
        check("pair_count", 64'(count_o), 64'd2);
        idle(1'b0, 1'b0, 3);

        // Fill to DEPTH, then one rejected push while full
        drive(1'b1, 32'h1C00_0008, 1'b1, 32'h1C00_000C, 1'b0, 1'b0);
        drive(1'b1, 32'h1C00_0010, 1'b1, 32'h1C00_0014, 1'b0, 1'b0);
        drive(1'b1, 32'h1C00_0018, 1'b1, 32'h1C00_001C, 1'b0, 1'b0);
        check("full_count", 64'(count_o), 64'd8);
        check("full_allowin", 64'(iq_if.now_allowin_o), 64'd0);
        drive(1'b1, 32'h1C00_0EE0, 1'b1, 32'h1C00_0EE4, 1'b0, 1'b0);
        check("blocked_count", 64'(count_o), 64'd8);

        // Single-issue drain
        idle(1'b1, 1'b0, 9);
        check("drained_count", 64'(count_o), 64'd0);

        // Steady state push 2 / pop 2 across pointer wrap
        pc = 32'h1C00_0100;
        drive(1'b1, pc, 1'b1, pc + 32'd4, 1'b0, 1'b0);
        pc += 32'd8;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, pc, 1'b1, pc + 32'd4, 1'b1, 1'b1);
            pc += 32'd8;
            check("steady_count", 64'(count_o), 64'd2);
        end
        idle(1'b1, 1'b1, 2);

        // Lane2-only push lands on line1
        drive(1'b0, 32'h0, 1'b1, 32'h1C00_0010, 1'b0, 1'b0);
        check("lane2_only_count", 64'(count_o), 64'd1);
        check("lane2_only_line2v", 64'(iq_if.line2_now_to_next_valid_o), 64'd0);
        idle(1'b0, 1'b0, 1);
        idle(1'b1, 1'b1, 2);

        // Count 5, then branch flush with push and pop in the same cycle
        drive(1'b1, 32'h1C00_0200, 1'b1, 32'h1C00_0204, 1'b0, 1'b0);
        drive(1'b1, 32'h1C00_0208, 1'b1, 32'h1C00_020C, 1'b0, 1'b0);
        drive(1'b1, 32'h1C00_0210, 1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_flush_count", 64'(count_o), 64'd5);
        drive(1'b1, 32'h1C00_0214, 1'b1, 32'h1C00_0218, 1'b1, 1'b0, 1'b1, 1'b0);
        check("post_flush_count", 64'(count_o), 64'd0);
        drive(1'b1, 32'h1C00_0300, 1'b1, 32'h1C00_0304, 1'b0, 1'b0);
        check("after_flush_count", 64'(count_o), 64'd2);

        // Exception flush empties a partially filled queue
        drive(1'b1, 32'h1C00_0308, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("excep_flush_count", 64'(count_o), 64'd0);
        drive(1'b0, 32'h0, 1'b1, 32'h1C00_0400, 1'b0, 1'b0);
        idle(1'b1, 1'b1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
